// File: rtl/load_unit.sv
// Multicycle load stage: one aligned 32-bit bus read per request, then byte/half/word
// extraction with sign or zero extension and a one-cycle done pulse to writeback.
`ifndef LOAD_OP_WIDTH
`define LOAD_OP_WIDTH 3
`define LOAD_OP_LB    3'b000
`define LOAD_OP_LH    3'b001
`define LOAD_OP_LW    3'b010
`define LOAD_OP_LBU   3'b100
`define LOAD_OP_LHU   3'b101
`endif

module load_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      start,
    input  logic [`LOAD_OP_WIDTH-1:0] LOADop,
    input  logic [31:0]               addr,
    output logic                      busy,
    output logic                      done,
    output logic [31:0]               rdata_out,
    output logic                      misaligned,
    output logic                      fault,
    output logic                      mem_valid,
    input  logic                      mem_ready,
    output logic [31:0]               mem_addr,
    input  logic [31:0]               mem_rdata,
    output logic [3:0]                mem_wstrb
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    localparam logic [15:0] TIMEOUT_LAST =
        (TIMEOUT_CYCLES == 0) ? 16'd0 : 16'(TIMEOUT_CYCLES - 1);

    state_t                    state_q;
    logic [`LOAD_OP_WIDTH-1:0] op_q;
    logic [1:0]                off_q;
    logic [15:0]               cnt_q;
    logic                      mem_valid_q;
    logic [31:0]               mem_addr_q;
    logic [31:0]               rdata_q;
    logic                      mis_q;
    logic                      fault_q;
    logic                      done_q;

    logic [31:0]               ext_d;
    logic                      legal_d;
    logic                      mis_d;

    function automatic logic is_legal(input logic [`LOAD_OP_WIDTH-1:0] op);
        case (op)
            `LOAD_OP_LB, `LOAD_OP_LH, `LOAD_OP_LW,
            `LOAD_OP_LBU, `LOAD_OP_LHU: is_legal = 1'b1;
            default:                    is_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] extract(input logic [`LOAD_OP_WIDTH-1:0] op,
                                            input logic [1:0]                off,
                                            input logic [31:0]               d);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[{off, 3'b000} +: 8];
        h = off[1] ? d[31:16] : d[15:0];
        case (op)
            `LOAD_OP_LB:  extract = {{24{b[7]}}, b};
            `LOAD_OP_LBU: extract = {24'b0, b};
            `LOAD_OP_LH:  extract = {{16{h[15]}}, h};
            `LOAD_OP_LHU: extract = {16'b0, h};
            `LOAD_OP_LW:  extract = d;
            default:      extract = 32'b0;
        endcase
    endfunction

    // Classification of the incoming request; only consulted while IDLE.
    always_comb begin
        legal_d = is_legal(LOADop);
        mis_d   = ((LOADop == `LOAD_OP_LH || LOADop == `LOAD_OP_LHU) && addr[0]) ||
                  ((LOADop == `LOAD_OP_LW) && (addr[1:0] != 2'b00));
        ext_d   = extract(op_q, off_q, mem_rdata);
    end

    // NOTE: every register, including mem_valid_q, is cleared by the async reset so the bus
    // request drops the moment resetn falls; all state updates use non-blocking assignments.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            off_q       <= 2'b00;
            cnt_q       <= 16'd0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= 32'b0;
            rdata_q     <= 32'b0;
            mis_q       <= 1'b0;
            fault_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q    <= LOADop;
                        off_q   <= addr[1:0];
                        cnt_q   <= 16'd0;
                        rdata_q <= 32'b0;
                        mis_q   <= 1'b0;
                        fault_q <= 1'b0;
                        if (!legal_d) begin
                            fault_q <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else if (mis_d) begin
                            mis_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            mem_addr_q  <= {addr[31:2], 2'b00};
                            mem_valid_q <= 1'b1;
                            state_q     <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_ready) begin
                        mem_valid_q <= 1'b0;
                        rdata_q     <= ext_d;
                        done_q      <= 1'b1;
                        state_q     <= S_DONE;
                    end else if (TIMEOUT_CYCLES != 0 && cnt_q == TIMEOUT_LAST) begin
                        mem_valid_q <= 1'b0;
                        fault_q     <= 1'b1;
                        done_q      <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign rdata_out  = rdata_q;
    assign misaligned = mis_q;
    assign fault      = fault_q;
    assign mem_valid  = mem_valid_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wstrb  = 4'b0000;

endmodule

// File: tb/tb_load_unit.sv
// Randomized bench for load_unit: a bus responder with random wait states, compared against
// an arithmetic model of load extraction, alignment rules, latency and timeout.
`ifndef LOAD_OP_WIDTH
`define LOAD_OP_WIDTH 3
`define LOAD_OP_LB    3'b000
`define LOAD_OP_LH    3'b001
`define LOAD_OP_LW    3'b010
`define LOAD_OP_LBU   3'b100
`define LOAD_OP_LHU   3'b101
`endif

module tb_load_unit;

    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [2:0]  LOADop;
    logic [31:0] addr;
    logic        busy, done, misaligned, fault, mem_valid, mem_ready;
    logic [31:0] rdata_out, mem_addr, mem_rdata;
    logic [3:0]  mem_wstrb;

    int n_checks = 0;
    int n_errors = 0;

    load_unit #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk), .resetn(resetn), .start(start), .LOADop(LOADop), .addr(addr),
        .busy(busy), .done(done), .rdata_out(rdata_out), .misaligned(misaligned),
        .fault(fault), .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_wstrb(mem_wstrb)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: result, flags, done latency (cycles after start) and bus request cycles.
    function automatic void ref_load(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] d, input int wt,
                                     output logic [31:0] r, output logic mis,
                                     output logic flt, output int lat, output int nv);
        int unsigned byte_sh = int'(a % 4) * 8;
        int unsigned half_sh = ((a % 4) >= 2) ? 16 : 0;
        logic [7:0]  b = 8'(d >> byte_sh);
        logic [15:0] h = 16'(d >> half_sh);
        r = 32'b0; mis = 1'b0; flt = 1'b0; lat = 1; nv = 0;
        if (!(op inside {`LOAD_OP_LB, `LOAD_OP_LH, `LOAD_OP_LW, `LOAD_OP_LBU, `LOAD_OP_LHU})) begin
            flt = 1'b1;
        end else if (((op == `LOAD_OP_LH || op == `LOAD_OP_LHU) && (a % 2 != 0)) ||
                     (op == `LOAD_OP_LW && (a % 4 != 0))) begin
            mis = 1'b1;
        end else if (wt >= TIMEOUT) begin
            flt = 1'b1; lat = TIMEOUT + 1; nv = TIMEOUT;
        end else begin
            lat = wt + 2; nv = wt + 1;
            case (op)
                `LOAD_OP_LB:  r = 32'($signed(b));
                `LOAD_OP_LBU: r = 32'(b);
                `LOAD_OP_LH:  r = 32'($signed(h));
                `LOAD_OP_LHU: r = 32'(h);
                default:      r = d;
            endcase
        end
    endfunction

    // Called one time unit after a rising edge; returns in the cycle after done.
    task automatic do_load(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d,
                           input int wt, input bit poke);
        logic [31:0] er, ema;
        logic        emis, eflt;
        int          elat, env, cyc, nv;
        bit          seen;
        ref_load(op, a, d, wt, er, emis, eflt, elat, env);
        ema = {a[31:2], 2'b00};
        start = 1'b1; LOADop = op; addr = a; mem_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; LOADop = 3'($urandom); addr = $urandom;
        cyc = 1; nv = 0; seen = 1'b0;
        while (cyc <= 40) begin
            if (done) begin seen = 1'b1; break; end
            check("busy", 32'(busy), 32'd1);
            if (cyc == 1) check("rdata_cleared", rdata_out, 32'd0);
            mem_rdata = $urandom;
            start = 1'b0;
            if (mem_valid) begin
                nv++;
                check("mem_addr", mem_addr, ema);
                if (poke && nv == 1) begin start = 1'b1; LOADop = `LOAD_OP_LW; addr = ema ^ 32'h0000_0F00; end
                mem_ready = (nv == wt + 1);
                if (mem_ready) mem_rdata = d;
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0; mem_ready = 1'b0;
        check("done_seen", 32'(seen), 32'd1);
        if (seen) begin
            check("latency", 32'(cyc), 32'(elat));
            check("valid_cycles", 32'(nv), 32'(env));
            check("rdata_out", rdata_out, er);
            check("misaligned", 32'(misaligned), 32'(emis));
            check("fault", 32'(fault), 32'(eflt));
            check("mem_wstrb", 32'(mem_wstrb), 32'd0);
            @(posedge clk); #1;
            check("done_pulse", 32'(done), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
            check("rdata_hold", rdata_out, er);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn = 1'b0; start = 1'b0; LOADop = '0; addr = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_valid", 32'(mem_valid), 32'd0);
        check("rst_rdata", rdata_out, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_flags", {30'd0, misaligned, fault}, 32'd0);
        resetn = 1'b1;
        @(posedge clk); #1;

        do_load(`LOAD_OP_LB,  32'h0000_1003, 32'h80FF_1234, 0, 1'b0);
        do_load(`LOAD_OP_LHU, 32'h0000_2002, 32'hBEEF_0000, 3, 1'b0);
        do_load(`LOAD_OP_LH,  32'h0000_2002, 32'hBEEF_0000, 3, 1'b0);
        do_load(`LOAD_OP_LW,  32'h0000_3001, 32'h1234_5678, 0, 1'b0);
        do_load(`LOAD_OP_LH,  32'h0000_3003, 32'h1234_5678, 0, 1'b0);
        do_load(`LOAD_OP_LW,  32'h0000_0040, 32'hCAFE_F00D, 100, 1'b0);
        do_load(3'b011,       32'h0000_0040, 32'hCAFE_F00D, 0, 1'b0);
        do_load(`LOAD_OP_LW,  32'h0000_4000, 32'h0BAD_BEEF, 3, 1'b1);

        // Reset asserted while a request is outstanding.
        start = 1'b1; LOADop = `LOAD_OP_LW; addr = 32'h0000_5000;
        @(posedge clk); #1;
        start = 1'b0; mem_ready = 1'b0;
        check("pre_rst_valid", 32'(mem_valid), 32'd1);
        @(posedge clk); #1;
        resetn = 1'b0;
        #1;
        check("midrst_valid", 32'(mem_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_mem_addr", mem_addr, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        do_load(`LOAD_OP_LBU, 32'h0000_6001, 32'h00C3_5A00, 1, 1'b0);

        // Back-to-back requests.
        do_load(`LOAD_OP_LW,  32'h0000_0010, 32'h8765_4321, 0, 1'b0);
        do_load(`LOAD_OP_LBU, 32'h0000_0015, 32'h0000_AB00, 0, 1'b0);

        for (int i = 0; i < 150; i++) begin
            do_load(3'($urandom_range(0, 7)), $urandom, $urandom,
                    $urandom_range(0, 9), ($urandom_range(0, 7) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
